lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 37 +++
 rtl/lsu.sv | 156 +++++++++++++++
 tb/tb_lsu.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 encodings and strobe patterns for the load/store unit
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] STRB_B = 4'b0001;
   localparam logic [3:0] STRB_H = 4'b0011;
   localparam logic [3:0] STRB_W = 4'b1111;

   // True only for a single-direction access with a defined size that is naturally aligned.
   function automatic logic access_ok(input logic ren, input logic wen,
                                      input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      ok = 1'b0;
      if (ren && !wen) begin
         case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
         endcase
      end else if (wen && !ren) begin
         case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            default:          ok = 1'b0;
         endcase
      end
      if ((f3[1:0] == 2'b01) && off[0]) ok = 1'b0;
      if ((f3[1:0] == 2'b10) && (off != 2'b00)) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering: store strobes/replication and load extraction/extension
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] resp_data,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);
   logic [31:0] shifted;

   always_comb begin
      shifted   = resp_data >> {offset, 3'b000};
      wstrb     = STRB_W;
      wdata     = store_data;
      load_data = shifted;
      case (funct3)
         F3_B: begin
            wstrb     = STRB_B << offset;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{shifted[7]}}, shifted[7:0]};
         end
         F3_H: begin
            wstrb     = STRB_H << offset;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{shifted[15]}}, shifted[15:0]};
         end
         F3_BU: load_data = {24'h0, shifted[7:0]};
         F3_HU: load_data = {16'h0, shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: execute-stage handshake, single bus access with watchdog, writeback result
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic        in_ren,
   input  logic        in_wen,
   input  logic [2:0]  in_funct3,
   input  logic [4:0]  in_rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_resp_valid,
   output logic        mem_resp_ready,
   input  logic [31:0] mem_resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_fault
);
   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        wen_q, wen_d;
   logic [7:0]  wdog_q, wdog_d;
   logic [31:0] out_data_q, out_data_d;
   logic [4:0]  out_rd_q, out_rd_d;
   logic        out_fault_q, out_fault_d;

   logic        mem_op, legal, wdog_expire;
   logic [3:0]  lane_wstrb;
   logic [31:0] lane_wdata, load_data;

   assign mem_op      = in_ren | in_wen;
   assign legal       = access_ok(in_ren, in_wen, in_funct3, in_addr[1:0]);
   assign wdog_expire = (32'(wdog_q) + 32'd1) >= TIMEOUT;

   lsu_align u_align (
      .funct3     (funct3_q),
      .offset     (addr_q[1:0]),
      .store_data (wdata_q),
      .resp_data  (mem_resp_data),
      .wstrb      (lane_wstrb),
      .wdata      (lane_wdata),
      .load_data  (load_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = (mem_op && legal) ? ST_REQ : ST_DONE;
         ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
         ST_WAIT: if (mem_resp_valid || wdog_expire) state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready       = 1'b0;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b0;
      out_valid      = 1'b0;
      case (state_q)
         ST_IDLE: in_ready       = 1'b1;
         ST_REQ:  mem_req_valid  = 1'b1;
         ST_WAIT: mem_resp_ready = 1'b1;
         ST_DONE: out_valid      = 1'b1;
         default: ;
      endcase
   end

   // out_data holds the address from capture onward so fault paths need no extra mux.
   always_comb begin
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      funct3_d    = funct3_q;
      wen_d       = wen_q;
      wdog_d      = wdog_q;
      out_data_d  = out_data_q;
      out_rd_d    = out_rd_q;
      out_fault_d = out_fault_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               addr_d      = in_addr;
               wdata_d     = in_wdata;
               funct3_d    = in_funct3;
               wen_d       = in_wen;
               out_data_d  = in_addr;
               out_rd_d    = in_rd;
               out_fault_d = mem_op && !legal;
            end
         end
         ST_REQ: if (mem_req_ready) wdog_d = 8'd0;
         ST_WAIT: begin
            if (mem_resp_valid) begin
               out_data_d  = wen_q ? 32'd0 : load_data;
               out_fault_d = 1'b0;
            end else begin
               wdog_d = wdog_q + 8'd1;
               if (wdog_expire) out_fault_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         funct3_q    <= 3'd0;
         wen_q       <= 1'b0;
         wdog_q      <= 8'd0;
         out_data_q  <= 32'd0;
         out_rd_q    <= 5'd0;
         out_fault_q <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         funct3_q    <= funct3_d;
         wen_q       <= wen_d;
         wdog_q      <= wdog_d;
         out_data_q  <= out_data_d;
         out_rd_q    <= out_rd_d;
         out_fault_q <= out_fault_d;
      end
   end

   assign mem_req_addr  = {addr_q[31:2], 2'b00};
   assign mem_req_wen   = wen_q;
   assign mem_req_wdata = lane_wdata;
   assign mem_req_wstrb = wen_q ? lane_wstrb : 4'b0000;
   assign out_data      = out_data_q;
   assign out_rd        = out_rd_q;
   assign out_fault     = out_fault_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu with a byte-level reference model
module tb_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_ren, in_wen;
   logic [31:0] in_addr, in_wdata;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_valid, mem_resp_ready;
   logic [31:0] mem_resp_data;
   logic        out_valid, out_ready, out_fault;
   logic [31:0] out_data;
   logic [4:0]  out_rd;

   int errors = 0;
   int checks = 0;

   logic        saw_req, stab_err, excl_err, hung;
   int          wait_cyc;
   logic [31:0] rq_addr, rq_wdata, o_data;
   logic        rq_wen, o_fault;
   logic [3:0]  rq_wstrb;
   logic [4:0]  o_rd;

   typedef struct packed {
      logic        is_mem;
      logic        legal;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] ldata;
   } exp_t;

   lsu #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_ren(in_ren), .in_wen(in_wen), .in_funct3(in_funct3), .in_rd(in_rd),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
      .out_fault(out_fault)
   );

   always #5 clk = ~clk;

   // Access size in bytes from funct3, then byte arithmetic on lanes.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd, input logic ren,
                                  input logic wen, input logic [2:0] f3, input logic [31:0] resp);
      exp_t e;
      int size, off;
      logic [31:0] v, mask;
      e = '0;
      size = 1 << f3[1:0];
      off = int'(a % 4);
      e.is_mem = ren | wen;
      if (ren && !wen) e.legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      else if (wen && !ren) e.legal = (f3 <= 3'd2);
      if ((off % size) != 0) e.legal = 1'b0;
      e.strb = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      v = resp >> (8 * off);
      if (size < 4) begin
         mask = (32'd1 << (8 * size)) - 32'd1;
         v = v & mask;
         if (!f3[2] && v[8*size-1]) v = v | ~mask;
      end
      e.ldata = v;
      return e;
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic ren, input logic wen,
                         input logic [2:0] f3, input logic [4:0] rd, input int req_dly,
                         input int resp_dly, input int out_dly, input bit drop, input logic [31:0] rdata);
      int rq, rs, od, guard;
      bit done;
      saw_req = 0; stab_err = 0; excl_err = 0; hung = 0; wait_cyc = 0;
      @(negedge clk);
      in_valid = 1'b1; in_addr = a; in_wdata = wd; in_ren = ren; in_wen = wen;
      in_funct3 = f3; in_rd = rd;
      guard = 0;
      while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
      @(negedge clk);
      in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
      in_funct3 = 3'($urandom); in_ren = 1'($urandom); in_wen = 1'($urandom);
      rq = 0; rs = 0; od = 0; done = 0; guard = 0;
      while (!done && guard < 100) begin
         if (int'(in_ready) + int'(mem_req_valid) + int'(mem_resp_ready) + int'(out_valid) != 1)
            excl_err = 1;
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
         if (mem_req_valid) begin
            if (!saw_req) begin
               rq_addr = mem_req_addr; rq_wen = mem_req_wen;
               rq_wdata = mem_req_wdata; rq_wstrb = mem_req_wstrb;
            end else if ({rq_addr, rq_wen, rq_wdata, rq_wstrb} !==
                         {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb}) stab_err = 1;
            saw_req = 1;
            if (rq == req_dly) mem_req_ready = 1'b1; else rq++;
         end
         if (mem_resp_ready) begin
            wait_cyc++;
            if (!drop && rs == resp_dly) begin
               mem_resp_valid = 1'b1; mem_resp_data = rdata;
            end else rs++;
         end else begin
            mem_resp_valid = 1'($urandom); mem_resp_data = $urandom;
         end
         if (out_valid) begin
            if (od == 0) begin
               o_data = out_data; o_rd = out_rd; o_fault = out_fault;
            end else if ({o_data, o_rd, o_fault} !== {out_data, out_rd, out_fault}) stab_err = 1;
            if (od == out_dly) begin out_ready = 1'b1; done = 1; end else od++;
         end
         @(negedge clk);
         guard++;
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
      if (!done) hung = 1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_req_valid, mem_resp_ready, out_valid, out_fault, out_rd, out_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got req_v=%b resp_rdy=%b out_v=%b fault=%b rd=%0d data=%h, expected all 0",
                  mem_req_valid, mem_resp_ready, out_valid, out_fault, out_rd, out_data);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_load_word();
      run_op(32'h8000_0004, 32'h0, 1'b1, 1'b0, 3'b010, 5'd7, 2, 1, 0, 1'b0, 32'hDEAD_BEEF);
      checks++;
      if ({hung, stab_err, excl_err} !== 3'b000) begin
         errors++; $display("FAIL lw_protocol: hung/unstable/excl=%b%b%b expected 000", hung, stab_err, excl_err);
      end
      checks++;
      if ({saw_req, rq_addr, rq_wen} !== {1'b1, 32'h8000_0004, 1'b0}) begin
         errors++; $display("FAIL lw_request: req=%b addr=%h wen=%b expected 1 80000004 0", saw_req, rq_addr, rq_wen);
      end
      checks++;
      if ({o_data, o_fault, o_rd} !== {32'hDEAD_BEEF, 1'b0, 5'd7}) begin
         errors++; $display("FAIL lw_result: data=%h fault=%b rd=%0d expected deadbeef 0 7", o_data, o_fault, o_rd);
      end
   endtask

   task automatic test_load_byte();
      logic [2:0]  f3s  [2] = '{3'b000, 3'b100};
      logic [31:0] exps [2] = '{32'hFFFF_FF80, 32'h0000_0080};
      for (int i = 0; i < 2; i++) begin
         run_op(32'h8000_0003, 32'h0, 1'b1, 1'b0, f3s[i], 5'd3, 0, 0, 0, 1'b0, 32'h80FF_FF7F);
         checks++;
         if ({hung, saw_req, rq_addr, o_data, o_fault} !== {1'b0, 1'b1, 32'h8000_0000, exps[i], 1'b0}) begin
            errors++;
            $display("FAIL lb_result[%0d]: hung=%b req=%b addr=%h data=%h fault=%b expected data %h",
                     i, hung, saw_req, rq_addr, o_data, o_fault, exps[i]);
         end
      end
   endtask

   task automatic test_store_half();
      run_op(32'h8000_0002, 32'h1234_ABCD, 1'b0, 1'b1, 3'b001, 5'd9, 1, 0, 0, 1'b0, 32'h5555_5555);
      checks++;
      if ({saw_req, rq_addr, rq_wen, rq_wstrb, rq_wdata} !==
          {1'b1, 32'h8000_0000, 1'b1, 4'b1100, 32'hABCD_ABCD}) begin
         errors++;
         $display("FAIL sh_request: req=%b addr=%h wen=%b strb=%b wdata=%h expected 1 80000000 1 1100 abcdabcd",
                  saw_req, rq_addr, rq_wen, rq_wstrb, rq_wdata);
      end
      checks++;
      if ({hung, o_data, o_fault, o_rd} !== {1'b0, 32'h0, 1'b0, 5'd9}) begin
         errors++; $display("FAIL sh_result: hung=%b data=%h fault=%b rd=%0d expected 0 0 0 9", hung, o_data, o_fault, o_rd);
      end
   endtask

   task automatic test_no_bus();
      logic [31:0] addrs [4] = '{32'h8000_0002, 32'h8000_0010, 32'h8000_0020, 32'h1234_5679};
      logic        rens  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic        wens  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3s   [4] = '{3'b010, 3'b010, 3'b011, 3'b000};
      logic        flts  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         run_op(addrs[i], 32'hCAFE_F00D, rens[i], wens[i], f3s[i], 5'(i + 1), 0, 0, 0, 1'b0, 32'h0);
         checks++;
         if ({hung, saw_req, o_data, o_fault, o_rd} !== {1'b0, 1'b0, addrs[i], flts[i], 5'(i + 1)}) begin
            errors++;
            $display("FAIL no_bus[%0d]: hung=%b req=%b data=%h fault=%b rd=%0d expected no req, data %h fault %b",
                     i, hung, saw_req, o_data, o_fault, o_rd, addrs[i], flts[i]);
         end
      end
   endtask

   task automatic test_timeout();
      run_op(32'h8000_0010, 32'h0, 1'b1, 1'b0, 3'b010, 5'd12, 0, 0, 0, 1'b1, 32'h0);
      checks++;
      if ({hung, wait_cyc, o_data, o_fault} !== {1'b0, 32'd4, 32'h8000_0010, 1'b1}) begin
         errors++;
         $display("FAIL timeout: hung=%b wait_cycles=%0d data=%h fault=%b expected 4 cycles, 80000010, 1",
                  hung, wait_cyc, o_data, o_fault);
      end
      run_op(32'h8000_0014, 32'h0, 1'b1, 1'b0, 3'b010, 5'd13, 0, 3, 0, 1'b0, 32'h0BAD_F00D);
      checks++;
      if ({hung, wait_cyc, o_data, o_fault} !== {1'b0, 32'd4, 32'h0BAD_F00D, 1'b0}) begin
         errors++;
         $display("FAIL late_response: hung=%b wait_cycles=%0d data=%h fault=%b expected 4 cycles, 0badf00d, 0",
                  hung, wait_cyc, o_data, o_fault);
      end
   endtask

   task automatic test_backpressure();
      run_op(32'h0000_0100, 32'hA5A5_5A5A, 1'b0, 1'b1, 3'b000, 5'd31, 0, 0, 5, 1'b0, 32'h0);
      checks++;
      if ({hung, stab_err, excl_err, o_data, o_rd} !== {3'b000, 32'h0, 5'd31}) begin
         errors++;
         $display("FAIL backpressure: hung/unstable/excl=%b%b%b data=%h rd=%0d expected 000 0 31",
                  hung, stab_err, excl_err, o_data, o_rd);
      end
   endtask

   task automatic test_reset_mid();
      bit bad;
      @(negedge clk);
      in_valid = 1'b1; in_addr = 32'h0000_0200; in_ren = 1'b1; in_wen = 1'b0;
      in_funct3 = 3'b010; in_rd = 5'd21;
      @(negedge clk);
      in_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      checks++;
      if (mem_resp_ready !== 1'b1) begin
         errors++; $display("FAIL reset_mid_wait: resp_ready=%b expected 1", mem_resp_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({mem_resp_ready, mem_req_valid, out_valid, out_rd, out_data, out_fault} !== '0) begin
         errors++;
         $display("FAIL reset_mid_async: resp_rdy=%b req_v=%b out_v=%b rd=%0d data=%h fault=%b expected all 0",
                  mem_resp_ready, mem_req_valid, out_valid, out_rd, out_data, out_fault);
      end
      @(negedge clk);
      rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_2222; out_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
      end
      mem_resp_valid = 1'b0;
      checks++;
      if (bad !== 1'b0) begin
         errors++; $display("FAIL reset_mid_abandon: stray output or not idle after release (got %b expected 0)", bad);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, wd, rdata, exp_data;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        ren, wen, exp_req, exp_fault;
      int          k;
      exp_t        e;
      for (int n = 0; n < 40; n++) begin
         a = $urandom; wd = $urandom; rdata = $urandom; rd = 5'($urandom);
         f3 = 3'($urandom_range(0, 7));
         k = $urandom_range(0, 9);
         ren = (k < 5); wen = (k >= 4) && (k < 9);
         if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
         e = model(a, wd, ren, wen, f3, rdata);
         run_op(a, wd, ren, wen, f3, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), 1'b0, rdata);
         exp_req   = e.is_mem && e.legal;
         exp_fault = e.is_mem && !e.legal;
         exp_data  = !exp_req ? a : (wen ? 32'h0 : e.ldata);
         checks++;
         if ({hung, stab_err, excl_err, saw_req} !== {3'b000, exp_req}) begin
            errors++;
            $display("FAIL rand_protocol[%0d]: hung/unstable/excl=%b%b%b req=%b expected 000 req=%b",
                     n, hung, stab_err, excl_err, saw_req, exp_req);
         end
         checks++;
         if ({o_data, o_fault, o_rd} !== {exp_data, exp_fault, rd}) begin
            errors++;
            $display("FAIL rand_result[%0d]: data=%h fault=%b rd=%0d expected %h %b %0d (addr=%h f3=%b ren=%b wen=%b)",
                     n, o_data, o_fault, o_rd, exp_data, exp_fault, rd, a, f3, ren, wen);
         end
         if (exp_req) begin
            checks++;
            if (rq_addr !== (a & 32'hFFFF_FFFC) || rq_wen !== wen ||
                (wen && (rq_wstrb !== e.strb || rq_wdata !== e.wdata))) begin
               errors++;
               $display("FAIL rand_request[%0d]: addr=%h wen=%b strb=%b wdata=%h expected %h %b %b %h",
                        n, rq_addr, rq_wen, rq_wstrb, rq_wdata, a & 32'hFFFF_FFFC, wen, e.strb, e.wdata);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_ren = 1'b0; in_wen = 1'b0;
      in_funct3 = '0; in_rd = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      mem_resp_data = '0; out_ready = 1'b0;
      test_reset();
      test_load_word();
      test_load_byte();
      test_store_half();
      test_no_bus();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_load_word();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
